// File: rtl/fft_pkg.sv
// Shared types and address arithmetic for the radix-2 ping-pong FFT stage scheduler.
// The bench reference model uses the same helpers.
package fft_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StDone
    } fft_state_e;

    function automatic int unsigned calc_aw(input int unsigned n);
        return $clog2(n);
    endfunction

    function automatic int unsigned calc_sw(input int unsigned n);
        return $clog2($clog2(n)) + 1;
    endfunction

    // Distance between the two butterfly inputs in a given stage.
    function automatic int unsigned bf_span(input int unsigned n, input int unsigned stage);
        return n >> (stage + 1);
    endfunction

    function automatic int unsigned bf_addr_a(input int unsigned n, input int unsigned stage,
                                              input int unsigned k);
        int unsigned mask;
        mask = bf_span(n, stage) - 1;
        return ((k & ~mask) << 1) | (k & mask);
    endfunction

    function automatic int unsigned bf_addr_b(input int unsigned n, input int unsigned stage,
                                              input int unsigned k);
        return bf_addr_a(n, stage, k) + bf_span(n, stage);
    endfunction

    function automatic int unsigned bf_tf_addr(input int unsigned n, input int unsigned stage,
                                               input int unsigned k);
        return (k & (bf_span(n, stage) - 1)) << stage;
    endfunction

endpackage

// File: rtl/fft_wr_delay_line.sv
// Fixed-depth shift register with a valid bit per slot; carries read-side write-back info
// across the butterfly pipeline. Synchronous flush drops every in-flight entry.
module fft_wr_delay_line #(
    parameter int unsigned Depth = 3,
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             valid_i,
    input  logic [Width-1:0] data_i,
    output logic             valid_o,
    output logic [Width-1:0] data_o
);

    logic [Depth-1:0] valid_q, valid_d;
    logic [Width-1:0] data_q [Depth];
    logic [Width-1:0] data_d [Depth];

    always_comb begin
        valid_d = '0;
        for (int i = 0; i < Depth; i++) begin
            data_d[i] = '0;
        end
        if (!flush_i) begin
            valid_d[0] = valid_i;
            data_d[0]  = data_i;
            for (int i = 1; i < Depth; i++) begin
                valid_d[i] = valid_q[i-1];
                data_d[i]  = data_q[i-1];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            for (int i = 0; i < Depth; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < Depth; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign valid_o = valid_q[Depth-1];
    assign data_o  = data_q[Depth-1];

endmodule

// File: rtl/fft_stage_scheduler.sv
// Stage/butterfly sequencer for a radix-2 ping-pong BRAM FFT: issues reads and twiddle
// addresses, and replays them as write-backs BF_LATENCY cycles later into the other bank.
module fft_stage_scheduler
    import fft_pkg::*;
#(
    parameter int unsigned N          = 64,
    parameter int unsigned BF_LATENCY = 3,
    localparam int unsigned AW = calc_aw(N),
    localparam int unsigned SW = calc_sw(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic [SW-1:0] stage,
    output logic          rd_en,
    output logic          rd_bank,
    output logic [AW-1:0] rd_addr_a,
    output logic [AW-1:0] rd_addr_b,
    output logic [AW-2:0] tf_addr,
    output logic          wr_en,
    output logic          wr_bank,
    output logic [AW-1:0] wr_addr_a,
    output logic [AW-1:0] wr_addr_b,
    output logic          result_bank
);

    localparam int unsigned KW = AW - 1;
    localparam int unsigned TW = AW - 1;
    localparam int unsigned CW = $clog2(BF_LATENCY + 1);
    localparam int unsigned DW = 2 * AW + 1;
    // Each stage swaps banks, so the result ends up in bank (number of stages) mod 2.
    localparam logic ResultBank = 1'(AW % 2);

    fft_state_e    state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [SW-1:0] stage_q, stage_d;
    logic [CW-1:0] drain_q, drain_d;
    logic          rd_bank_q, rd_bank_d;
    logic          rd_en_q, rd_en_d;
    logic [AW-1:0] rd_addr_a_q, rd_addr_a_d;
    logic [AW-1:0] rd_addr_b_q, rd_addr_b_d;
    logic [TW-1:0] tf_addr_q, tf_addr_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          result_bank_q;
    logic          flush;
    logic [DW-1:0] dl_in, dl_out;

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        stage_d   = stage_q;
        drain_d   = drain_q;
        rd_bank_d = rd_bank_q;
        flush     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    state_d   = StIssue;
                    k_d       = '0;
                    stage_d   = '0;
                    rd_bank_d = 1'b0;
                end
            end
            StIssue: begin
                if (k_q == KW'(N / 2 - 1)) begin
                    state_d = StDrain;
                    drain_d = '0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            StDrain: begin
                if (drain_q == CW'(BF_LATENCY - 1)) begin
                    if (stage_q == SW'(AW - 1)) begin
                        state_d = StDone;
                    end else begin
                        state_d   = StIssue;
                        stage_d   = stage_q + 1'b1;
                        rd_bank_d = ~rd_bank_q;
                        k_d       = '0;
                    end
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            StDone: begin
                state_d   = StIdle;
                stage_d   = '0;
                rd_bank_d = 1'b0;
            end
        endcase

        if (abort && state_q != StIdle) begin
            state_d   = StIdle;
            k_d       = '0;
            stage_d   = '0;
            rd_bank_d = 1'b0;
            flush     = 1'b1;
        end
    end

    // Outputs are registered from the next-state values so they line up with state_q.
    always_comb begin
        rd_en_d     = (state_d == StIssue);
        busy_d      = (state_d != StIdle);
        done_d      = (state_d == StDone);
        rd_addr_a_d = '0;
        rd_addr_b_d = '0;
        tf_addr_d   = '0;
        if (rd_en_d) begin
            rd_addr_a_d = AW'(bf_addr_a(N, 32'(stage_d), 32'(k_d)));
            rd_addr_b_d = AW'(bf_addr_b(N, 32'(stage_d), 32'(k_d)));
            tf_addr_d   = TW'(bf_tf_addr(N, 32'(stage_d), 32'(k_d)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            k_q           <= '0;
            stage_q       <= '0;
            drain_q       <= '0;
            rd_bank_q     <= 1'b0;
            rd_en_q       <= 1'b0;
            rd_addr_a_q   <= '0;
            rd_addr_b_q   <= '0;
            tf_addr_q     <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            result_bank_q <= ResultBank;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            stage_q       <= stage_d;
            drain_q       <= drain_d;
            rd_bank_q     <= rd_bank_d;
            rd_en_q       <= rd_en_d;
            rd_addr_a_q   <= rd_addr_a_d;
            rd_addr_b_q   <= rd_addr_b_d;
            tf_addr_q     <= tf_addr_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            result_bank_q <= result_bank_q;
        end
    end

    assign dl_in = rd_en_q ? {rd_addr_a_q, rd_addr_b_q, ~rd_bank_q} : '0;

    fft_wr_delay_line #(
        .Depth(BF_LATENCY),
        .Width(DW)
    ) u_wr_delay_line (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .flush_i(flush),
        .valid_i(rd_en_q),
        .data_i (dl_in),
        .valid_o(wr_en),
        .data_o (dl_out)
    );

    assign {wr_addr_a, wr_addr_b, wr_bank} = dl_out;

    assign busy        = busy_q;
    assign done        = done_q;
    assign stage       = stage_q;
    assign rd_en       = rd_en_q;
    assign rd_bank     = rd_bank_q;
    assign rd_addr_a   = rd_addr_a_q;
    assign rd_addr_b   = rd_addr_b_q;
    assign tf_addr     = tf_addr_q;
    assign result_bank = result_bank_q;

endmodule
